out_port_arbiter: RTL

- Per-output-port controller for the 5-port mesh switch. Shares one output link (L, N, E, S or W) among the five input FIFOs.
- Arbitration is round-robin at packet granularity. Once granted, a packet is locked to the output until its end-of-packet (endbit) flit is sent, i.e. wormhole switching.
- It pops flits from the granted show-ahead input FIFO and drives the link through a registered output stage using the Outw/Outr handshake.
- Five instances live inside the switch, one per output direction.

---
 rtl/out_port_arbiter_if.sv | 35 +++
 rtl/out_port_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/out_port_arbiter_if.sv
// rtl/out_port_arbiter_if.sv - signal bundle between one output port arbiter and the switch
// Purpose: groups the FIFO-side and link-side signals of one output port.
// Signals:
//   req      FIFO i non-empty with its head routed to this output
//   flit_in  head flits of all FIFOs, FIFO i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rdreq    one-hot pop strobe back to the FIFOs
//   dataOut  registered flit towards the downstream link
//   Outw     dataOut holds a flit
//   Outr     downstream ready
//   grant    one-hot current owner of the output, zero when idle
//   busy     a packet is locked to the output
// Modports: master = arbiter side, slave = switch/environment side.
interface out_port_arbiter_if #(
  parameter int DATA_WIDTH = 37,
  parameter int NUM_REQ    = 5
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] flit_in;
  logic [NUM_REQ-1:0]            rdreq;
  logic [DATA_WIDTH-1:0]         dataOut;
  logic                          Outw;
  logic                          Outr;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;

  modport master (
    input  req, flit_in, Outr,
    output rdreq, dataOut, Outw, grant, busy
  );

  modport slave (
    output req, flit_in, Outr,
    input  rdreq, dataOut, Outw, grant, busy
  );
endinterface

// File: rtl/out_port_arbiter.sv
// rtl/out_port_arbiter.sv - wormhole round-robin arbiter for one mesh switch output port
// Purpose: shares one output link among NUM_REQ show-ahead input FIFOs. A packet
//   wins in IDLE by round-robin, then owns the link until its endbit flit is
//   popped. Flits leave through a registered stage using the Outw/Outr handshake.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    out_port_arbiter_if.master (req, flit_in, rdreq, dataOut, Outw, Outr, grant, busy)
// Optional feature: define OUT_ARB_LOCAL_PRIO_EN to give the local input (index 0)
//   absolute priority in IDLE; the remaining inputs rotate round-robin.
module out_port_arbiter #(
  parameter int DATA_WIDTH = 37,
  parameter int NUM_REQ    = 5,
  parameter int PTR_W      = 3
) (
  input logic                clk,
  input logic                reset,
  out_port_arbiter_if.master bus
);

`ifdef OUT_ARB_LOCAL_PRIO_EN
  localparam bit LOCAL_PRIO = 1'b1;
`else
  localparam bit LOCAL_PRIO = 1'b0;
`endif

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t                state;
  state_t                next_state;
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      gnt_idx;
  logic [PTR_W-1:0]      sel_idx;
  logic                  sel_valid;
  logic [NUM_REQ-1:0]    grant_q;
  logic [NUM_REQ-1:0]    rdreq_c;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] head_flit;
  logic                  outw_q;
  logic                  busy_c;
  logic                  can_load;
  logic                  pop;
  logic                  eop;

  assign head_flit = bus.flit_in[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign eop       = pop && head_flit[DATA_WIDTH-1];

  // Round-robin pick starting at rr_ptr. The candidate index is reduced modulo
  // NUM_REQ before use, so a pointer near the top never reaches a missing input.
  always_comb begin
    int               cand;
    logic [PTR_W-1:0] cand_idx;
    cand      = 0;
    cand_idx  = '0;
    sel_idx   = '0;
    sel_valid = 1'b0;
    if (LOCAL_PRIO && bus.req[0]) begin
      sel_valid = 1'b1;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = cand[PTR_W-1:0];
      if (!sel_valid && bus.req[cand_idx] && !(LOCAL_PRIO && cand == 0)) begin
        sel_idx   = cand_idx;
        sel_valid = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (sel_valid) next_state = LOCK;
      LOCK:    if (eop)       next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic: pop only while locked, the owner has a flit, and the output
  // register is free or draining this cycle. Reset suppresses any pop.
  always_comb begin
    can_load = !outw_q || bus.Outr;
    pop      = (state == LOCK) && !reset && bus.req[gnt_idx] && can_load;
    rdreq_c  = '0;
    if (pop) rdreq_c[gnt_idx] = 1'b1;
    busy_c   = (state == LOCK);
  end

  // Grant and round-robin pointer; the pointer moves only when a packet ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q <= '0;
      gnt_idx <= '0;
      rr_ptr  <= '0;
    end else if (state == IDLE) begin
      if (sel_valid) begin
        gnt_idx <= sel_idx;
        grant_q <= NUM_REQ'(1) << sel_idx;
      end
    end else if (eop) begin
      grant_q <= '0;
      rr_ptr  <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Registered link stage
  always_ff @(posedge clk) begin
    if (reset) begin
      outw_q <= 1'b0;
      data_q <= '0;
    end else if (pop) begin
      outw_q <= 1'b1;
      data_q <= head_flit;
    end else if (bus.Outr) begin
      outw_q <= 1'b0;
    end
  end

  assign bus.rdreq   = rdreq_c;
  assign bus.dataOut = data_q;
  assign bus.Outw    = outw_q;
  assign bus.grant   = grant_q;
  assign bus.busy    = busy_c;

endmodule
